// File: rtl/spram_pkg.sv
// spram_pkg -- shared types and helpers for the spram_ctrl scratchpad RAM.
//   spram_state_e : controller state (zeroing sweep / normal operation)
//   byte_parity() : even-parity bit for one byte (XOR of its bits)
//   spram_cfg_ok(): legality check for the data width and read latency
// The optional parity storage is enabled by defining SPRAM_PARITY_EN.
package spram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } spram_state_e;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_READ_LAT   = 1;

  // Stored bit makes the byte plus its parity bit carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic bit spram_cfg_ok(input int data_width, input int read_lat);
    return (data_width > 0) && (data_width % 8 == 0) &&
           ((read_lat == 1) || (read_lat == 2));
  endfunction

endpackage

// File: rtl/spram_array.sv
// spram_array -- single-port storage with byte-enabled write and registered read.
// Ports:
//   clk      : clock, rising edge
//   we       : write strobe; only bytes with be[i]=1 are updated
//   re       : read strobe; rd_data captures mem[addr] at the edge
//   be       : byte enables, bit i covers wdata[8i+7:8i]
//   addr     : word address shared by read and write
//   wdata    : write data
//   rd_data  : registered read data (updates only on re)
//   rd_perr  : stored parity disagrees with rd_data (0 when parity is off)
// Define SPRAM_PARITY_EN to store one even-parity bit per byte.
module spram_array
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_perr
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rd_data <= mem[addr];
  end

`ifdef SPRAM_PARITY_EN
  logic [NUM_BYTES-1:0] par_mem [DEPTH];
  logic [NUM_BYTES-1:0] rd_par;

  // Parity bits follow their byte enables, so a partial write leaves the
  // other bytes' parity (and any latent corruption) untouched.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (be[i]) par_mem[addr][i] <= byte_parity(wdata[8*i +: 8]);
      end
    end
    if (re) rd_par <= par_mem[addr];
  end

  always_comb begin
    rd_perr = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      rd_perr = rd_perr | (byte_parity(rd_data[8*i +: 8]) != rd_par[i]);
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: rtl/spram_ctrl.sv
// spram_ctrl -- generic scratchpad RAM with valid/ready requests, byte write
// enables, READ_LAT (1 or 2) cycle reads and a hardware zeroing sweep after
// reset or clr.
// Ports:
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   clr                : one-cycle pulse; restarts the sweep when running
//   req_valid/req_ready: request handshake, accepted when both are high
//   rdn_wr             : 0 = read, 1 = write
//   addr, data_in      : word address and write data
//   wr_be              : per-byte write enables
//   rsp_valid          : one-cycle pulse with read data
//   data_out           : read data, held between responses
//   init_done          : array has been zeroed and is usable
//   parity_err         : parity mismatch on the current response
// Define SPRAM_PARITY_EN to enable per-byte parity storage and checking;
// otherwise parity_err is constant 0.
module spram_ctrl
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = DEF_READ_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    rdn_wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    init_done,
  output logic                    parity_err
);

  localparam int                    NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (!spram_cfg_ok(DATA_WIDTH, READ_LAT)) begin : g_bad_cfg
    $error("spram_ctrl: DATA_WIDTH must be a multiple of 8 and READ_LAT must be 1 or 2");
  end

  spram_state_e          state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  accept;

  assign accept = req_valid && req_ready;

  // req_ready/init_done are registered copies of "state == ST_RUN".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // A request accepted in the same cycle still completes: the array
          // strobes below come from accept, not from the next state.
          if (clr) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  logic                  mem_we;
  logic                  mem_re;
  logic [NUM_BYTES-1:0]  mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic                  rd_perr_p0;

  // The sweep owns the single port while initialising.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = wr_be;
    mem_addr  = addr;
    mem_wdata = data_in;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_addr  = init_cnt;
      mem_wdata = '0;
    end else if (accept) begin
      mem_we = rdn_wr;
      mem_re = !rdn_wr;
    end
  end

  spram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .re      (mem_re),
    .be      (mem_be),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rd_data (rd_data_p0),
    .rd_perr (rd_perr_p0)
  );

  // ---- stage p0: array read register (inside spram_array) ----
  logic vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= mem_re;
  end

  // ---- stage p1: first output register ----
  logic                  vld_p1;
  logic                  perr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Data registers carry a reset because data_out must read 0 after reset;
  // they load only with a valid so the last response is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      perr_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      perr_p1 <= vld_p0 && rd_perr_p0;
      if (vld_p0) data_p1 <= rd_data_p0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    // ---- stage p2: extra output register for READ_LAT=2 ----
    logic                  vld_p2;
    logic                  perr_p2;
    logic [DATA_WIDTH-1:0] data_p2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2  <= 1'b0;
        perr_p2 <= 1'b0;
        data_p2 <= '0;
      end else begin
        vld_p2  <= vld_p1;
        perr_p2 <= perr_p1;
        if (vld_p1) data_p2 <= data_p1;
      end
    end

    assign rsp_valid  = vld_p2;
    assign data_out   = data_p2;
    assign parity_err = perr_p2;
  end else begin : g_lat1
    assign rsp_valid  = vld_p1;
    assign data_out   = data_p1;
    assign parity_err = perr_p1;
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl -- self-checking bench for spram_ctrl. Two instances share
// the request inputs: dut1 with READ_LAT=1 and dut2 with READ_LAT=2, both
// with ADDR_WIDTH=4 (16 words). Expected values come from a word-array model
// and the rule "read driven before edge k+1 appears after edge k+1+READ_LAT".
module tb_spram_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int N_RAND = 160;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          req_valid;
  logic          rdn_wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [3:0]    wr_be;

  logic          req_ready1, rsp_valid1, init_done1, parity_err1;
  logic [DW-1:0] data_out1;
  logic          req_ready2, rsp_valid2, init_done2, parity_err2;
  logic [DW-1:0] data_out2;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          v1, v1a, p1, p1a, v2, v2a, p2;
    logic [DW-1:0] d1, d2;
  } rd_obs_t;

  spram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid),
    .req_ready(req_ready1), .rdn_wr(rdn_wr), .addr(addr), .data_in(data_in),
    .wr_be(wr_be), .rsp_valid(rsp_valid1), .data_out(data_out1),
    .init_done(init_done1), .parity_err(parity_err1)
  );

  spram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid),
    .req_ready(req_ready2), .rdn_wr(rdn_wr), .addr(addr), .data_in(data_in),
    .wr_be(wr_be), .rsp_valid(rsp_valid2), .data_out(data_out2),
    .init_done(init_done2), .parity_err(parity_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    rdn_wr    = 1'b0;
    clr       = 1'b0;
    addr      = '0;
    data_in   = '0;
    wr_be     = '0;
  endtask

  task automatic write_once(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] be);
    req_valid = 1'b1; rdn_wr = 1'b1; addr = a; data_in = d; wr_be = be;
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    drive_idle();
  endtask

  task automatic read_once(input logic [AW-1:0] a, output rd_obs_t o);
    req_valid = 1'b1; rdn_wr = 1'b0; addr = a;
    data_in = $urandom; wr_be = 4'($urandom);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    o.v1 = rsp_valid1; o.d1 = data_out1; o.p1 = parity_err1;
    @(negedge clk);
    o.v1a = rsp_valid1; o.p1a = parity_err1;
    o.v2 = rsp_valid2; o.d2 = data_out2; o.p2 = parity_err2;
    @(negedge clk);
    o.v2a = rsp_valid2;
  endtask

  // Returns edges elapsed from 'start' until each init_done is seen, -1 on timeout.
  task automatic wait_init(input int start, output int n1, output int n2);
    n1 = -1; n2 = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (init_done1 && n1 < 0) n1 = edge_cnt - start;
      if (init_done2 && n2 < 0) n2 = edge_cnt - start;
      if (n1 >= 0 && n2 >= 0) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int start, n1, n2;
    rst_n = 1'b1;
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req_ready1 !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req_ready1); end
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp1: got %b want 0", rsp_valid1); end
    checks++; if (data_out1 !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h want 0", data_out1); end
    checks++; if (init_done1 !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b want 0", init_done1); end
    checks++; if (parity_err1 !== 1'b0) begin errors++; $display("FAIL reset_perr1: got %b want 0", parity_err1); end
    checks++; if (req_ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b want 0", req_ready2); end
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL reset_rsp2: got %b want 0", rsp_valid2); end
    checks++; if (data_out2 !== 32'h0) begin errors++; $display("FAIL reset_data2: got %h want 0", data_out2); end
    checks++; if (init_done2 !== 1'b0) begin errors++; $display("FAIL reset_done2: got %b want 0", init_done2); end
    checks++; if (parity_err2 !== 1'b0) begin errors++; $display("FAIL reset_perr2: got %b want 0", parity_err2); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = edge_cnt;
    wait_init(start, n1, n2);
    checks++; if (n1 != DEPTH) begin errors++; $display("FAIL sweep_len1: got %0d edges want %0d", n1, DEPTH); end
    checks++; if (n2 != DEPTH) begin errors++; $display("FAIL sweep_len2: got %0d edges want %0d", n2, DEPTH); end
    checks++; if (req_ready1 !== 1'b1) begin errors++; $display("FAIL ready_after_sweep1: got %b want 1", req_ready1); end
    checks++; if (req_ready2 !== 1'b1) begin errors++; $display("FAIL ready_after_sweep2: got %b want 1", req_ready2); end
    clear_model();
  endtask

  task automatic test_init_zero();
    rd_obs_t o;
    for (int a = 0; a < DEPTH; a++) begin
      read_once(AW'(a), o);
      checks++; if (o.v1 !== 1'b1) begin errors++; $display("FAIL zero_vld1 a=%0d: got %b want 1", a, o.v1); end
      checks++; if (o.d1 !== 32'h0) begin errors++; $display("FAIL zero_data1 a=%0d: got %h want 0", a, o.d1); end
      checks++; if (o.v1a !== 1'b0) begin errors++; $display("FAIL zero_width1 a=%0d: got %b want 0", a, o.v1a); end
      checks++; if (o.v2 !== 1'b1) begin errors++; $display("FAIL zero_vld2 a=%0d: got %b want 1", a, o.v2); end
      checks++; if (o.d2 !== 32'h0) begin errors++; $display("FAIL zero_data2 a=%0d: got %h want 0", a, o.d2); end
      checks++; if (o.v2a !== 1'b0) begin errors++; $display("FAIL zero_width2 a=%0d: got %b want 0", a, o.v2a); end
    end
  endtask

  task automatic test_byte_enable();
    rd_obs_t o;
    write_once(4'd3, 32'hDEADBEEF, 4'b1111);
    write_once(4'd3, 32'h00000011, 4'b0001);
    read_once(4'd3, o);
    checks++; if (o.v1 !== 1'b1 || o.d1 !== 32'hDEADBE11) begin errors++; $display("FAIL be_read1: got v=%b %h want v=1 DEADBE11", o.v1, o.d1); end
    checks++; if (o.v2 !== 1'b1 || o.d2 !== 32'hDEADBE11) begin errors++; $display("FAIL be_read2: got v=%b %h want v=1 DEADBE11", o.v2, o.d2); end
    write_once(4'd3, 32'hFFFFFFFF, 4'b0000);
    read_once(4'd3, o);
    checks++; if (o.d1 !== 32'hDEADBE11) begin errors++; $display("FAIL be_zero_noop1: got %h want DEADBE11", o.d1); end
    checks++; if (o.d2 !== 32'hDEADBE11) begin errors++; $display("FAIL be_zero_noop2: got %h want DEADBE11", o.d2); end
    write_once(4'd3, 32'h77665544, 4'b1010);
    read_once(4'd3, o);
    checks++; if (o.d1 !== ref_mem[3]) begin errors++; $display("FAIL be_mixed1: got %h want %h", o.d1, ref_mem[3]); end
    checks++; if (o.d2 !== ref_mem[3]) begin errors++; $display("FAIL be_mixed2: got %h want %h", o.d2, ref_mem[3]); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ra [3];
    logic [DW-1:0] rd [3];
    logic          ev1, ev2;
    // write then read of the same address on consecutive cycles
    req_valid = 1'b1; rdn_wr = 1'b1; addr = 4'd7; data_in = 32'hA5A5A5A5; wr_be = 4'hF;
    ref_mem[7] = 32'hA5A5A5A5;
    @(negedge clk);
    rdn_wr = 1'b0; data_in = '0;
    @(negedge clk);
    drive_idle();
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL write_no_rsp: got %b want 0", rsp_valid1); end
    @(negedge clk);
    checks++; if (rsp_valid1 !== 1'b1 || data_out1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL raw1: got v=%b %h want v=1 A5A5A5A5", rsp_valid1, data_out1); end
    @(negedge clk);
    checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL raw_width1: got %b want 0", rsp_valid1); end
    checks++; if (rsp_valid2 !== 1'b1 || data_out2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL raw2: got v=%b %h want v=1 A5A5A5A5", rsp_valid2, data_out2); end
    @(negedge clk);
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL raw_width2: got %b want 0", rsp_valid2); end
    // three reads on consecutive cycles
    ra[0] = 4'd3; ra[1] = 4'd7; ra[2] = 4'd0;
    for (int i = 0; i < 3; i++) rd[i] = ref_mem[ra[i]];
    for (int j = 0; j < 7; j++) begin
      ev1 = (j >= 2 && j <= 4);
      ev2 = (j >= 3 && j <= 5);
      checks++; if (rsp_valid1 !== ev1) begin errors++; $display("FAIL b2b_vld1 j=%0d: got %b want %b", j, rsp_valid1, ev1); end
      if (ev1) begin
        checks++; if (data_out1 !== rd[j-2]) begin errors++; $display("FAIL b2b_data1 j=%0d: got %h want %h", j, data_out1, rd[j-2]); end
      end
      checks++; if (rsp_valid2 !== ev2) begin errors++; $display("FAIL b2b_vld2 j=%0d: got %b want %b", j, rsp_valid2, ev2); end
      if (ev2) begin
        checks++; if (data_out2 !== rd[j-3]) begin errors++; $display("FAIL b2b_data2 j=%0d: got %h want %h", j, data_out2, rd[j-3]); end
      end
      if (j < 3) begin req_valid = 1'b1; rdn_wr = 1'b0; addr = ra[j]; end
      else drive_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_parity();
    rd_obs_t o;
    logic    par_on;
`ifdef SPRAM_PARITY_EN
    par_on = 1'b1;
`else
    par_on = 1'b0;
`endif
    write_once(4'd2, 32'h0F0F1234, 4'hF);
    write_once(4'd9, 32'h00FF0101, 4'hF);
`ifdef SPRAM_PARITY_EN
    dut1.u_array.par_mem[2][0] = ~dut1.u_array.par_mem[2][0];
    dut2.u_array.par_mem[2][0] = ~dut2.u_array.par_mem[2][0];
`endif
    read_once(4'd2, o);
    checks++; if (o.v1 !== 1'b1 || o.d1 !== 32'h0F0F1234) begin errors++; $display("FAIL par_data1: got v=%b %h want v=1 0F0F1234", o.v1, o.d1); end
    checks++; if (o.p1 !== par_on) begin errors++; $display("FAIL par_err1: got %b want %b", o.p1, par_on); end
    checks++; if (o.p2 !== par_on) begin errors++; $display("FAIL par_err2: got %b want %b", o.p2, par_on); end
    checks++; if (o.p1a !== 1'b0) begin errors++; $display("FAIL par_err_after_rsp1: got %b want 0", o.p1a); end
    read_once(4'd9, o);
    checks++; if (o.p1 !== 1'b0 || o.p2 !== 1'b0) begin errors++; $display("FAIL par_clean: got %b/%b want 0/0", o.p1, o.p2); end
    // rewriting byte 1 only keeps the corrupted byte-0 parity
    write_once(4'd2, 32'h0000AB00, 4'b0010);
    read_once(4'd2, o);
    checks++; if (o.p1 !== par_on || o.p2 !== par_on) begin errors++; $display("FAIL par_partial: got %b/%b want %b", o.p1, o.p2, par_on); end
    checks++; if (o.d1 !== ref_mem[2]) begin errors++; $display("FAIL par_partial_data: got %h want %h", o.d1, ref_mem[2]); end
    // rewriting byte 0 repairs it
    write_once(4'd2, 32'h000000CD, 4'b0001);
    read_once(4'd2, o);
    checks++; if (o.p1 !== 1'b0 || o.p2 !== 1'b0) begin errors++; $display("FAIL par_repair: got %b/%b want 0/0", o.p1, o.p2); end
    checks++; if (o.d2 !== ref_mem[2]) begin errors++; $display("FAIL par_repair_data: got %h want %h", o.d2, ref_mem[2]); end
  endtask

  task automatic test_random();
    logic          ev [N_RAND];
    logic [DW-1:0] ed [N_RAND];
    logic [DW-1:0] last1, last2;
    logic          has1, has2;
    int            op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
    has1 = 1'b0; has2 = 1'b0; last1 = '0; last2 = '0;
    for (int j = 0; j < N_RAND + 4; j++) begin
      if (j >= 2 && j - 2 < N_RAND) begin
        checks++; if (rsp_valid1 !== ev[j-2]) begin errors++; $display("FAIL rand_vld1 j=%0d: got %b want %b", j, rsp_valid1, ev[j-2]); end
        if (ev[j-2]) begin
          checks++; if (data_out1 !== ed[j-2] || parity_err1 !== 1'b0) begin errors++; $display("FAIL rand_data1 j=%0d: got %h pe=%b want %h pe=0", j, data_out1, parity_err1, ed[j-2]); end
          last1 = ed[j-2]; has1 = 1'b1;
        end else if (has1) begin
          checks++; if (data_out1 !== last1) begin errors++; $display("FAIL rand_hold1 j=%0d: got %h want %h", j, data_out1, last1); end
        end
      end
      if (j >= 3 && j - 3 < N_RAND) begin
        checks++; if (rsp_valid2 !== ev[j-3]) begin errors++; $display("FAIL rand_vld2 j=%0d: got %b want %b", j, rsp_valid2, ev[j-3]); end
        if (ev[j-3]) begin
          checks++; if (data_out2 !== ed[j-3] || parity_err2 !== 1'b0) begin errors++; $display("FAIL rand_data2 j=%0d: got %h pe=%b want %h pe=0", j, data_out2, parity_err2, ed[j-3]); end
          last2 = ed[j-3]; has2 = 1'b1;
        end else if (has2) begin
          checks++; if (data_out2 !== last2) begin errors++; $display("FAIL rand_hold2 j=%0d: got %h want %h", j, data_out2, last2); end
        end
      end
      if (j < N_RAND) begin
        op = $urandom_range(0, 2);
        a  = AW'($urandom);
        d  = $urandom;
        be = 4'($urandom);
        ev[j] = 1'b0; ed[j] = '0;
        req_valid = (op != 2); rdn_wr = (op == 1); addr = a; data_in = d; wr_be = be;
        if (op == 0) begin
          ev[j] = 1'b1; ed[j] = ref_mem[a];
        end else if (op == 1) begin
          for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        drive_idle();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clr_with_read();
    rd_obs_t o;
    int      start, n1, n2;
    write_once(4'd5, 32'h12345678, 4'hF);
    req_valid = 1'b1; rdn_wr = 1'b0; addr = 4'd5; clr = 1'b1;
    @(negedge clk);
    drive_idle();
    start = edge_cnt;
    checks++; if (req_ready1 !== 1'b0 || req_ready2 !== 1'b0) begin errors++; $display("FAIL clr_ready_fall: got %b/%b want 0/0", req_ready1, req_ready2); end
    checks++; if (init_done1 !== 1'b0 || init_done2 !== 1'b0) begin errors++; $display("FAIL clr_done_fall: got %b/%b want 0/0", init_done1, init_done2); end
    @(negedge clk);
    checks++; if (rsp_valid1 !== 1'b1 || data_out1 !== 32'h12345678) begin errors++; $display("FAIL clr_rsp1: got v=%b %h want v=1 12345678", rsp_valid1, data_out1); end
    @(negedge clk);
    checks++; if (rsp_valid2 !== 1'b1 || data_out2 !== 32'h12345678) begin errors++; $display("FAIL clr_rsp2: got v=%b %h want v=1 12345678", rsp_valid2, data_out2); end
    clr = 1'b1;  // pulse while sweeping: must not restart it
    @(negedge clk);
    clr = 1'b0;
    checks++; if (data_out1 !== 32'h12345678) begin errors++; $display("FAIL clr_hold1: got %h want 12345678", data_out1); end
    wait_init(start, n1, n2);
    checks++; if (n1 != DEPTH) begin errors++; $display("FAIL clr_sweep_len1: got %0d edges want %0d", n1, DEPTH); end
    checks++; if (n2 != DEPTH) begin errors++; $display("FAIL clr_sweep_len2: got %0d edges want %0d", n2, DEPTH); end
    clear_model();
    read_once(4'd5, o);
    checks++; if (o.v1 !== 1'b1 || o.d1 !== 32'h0) begin errors++; $display("FAIL clr_zeroed1: got v=%b %h want v=1 0", o.v1, o.d1); end
    checks++; if (o.v2 !== 1'b1 || o.d2 !== 32'h0) begin errors++; $display("FAIL clr_zeroed2: got v=%b %h want v=1 0", o.v2, o.d2); end
  endtask

  task automatic test_reset_mid_op();
    rd_obs_t o;
    int      start, n1, n2;
    logic    stale;
    // reset while a read is in flight
    write_once(4'd7, 32'hCAFEF00D, 4'hF);
    read_once(4'd9, o);
    req_valid = 1'b1; rdn_wr = 1'b0; addr = 4'd7;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    drive_idle();
    checks++; if (rsp_valid1 !== 1'b0 || rsp_valid2 !== 1'b0) begin errors++; $display("FAIL rst_read_rsp: got %b/%b want 0/0", rsp_valid1, rsp_valid2); end
    checks++; if (data_out1 !== 32'h0 || data_out2 !== 32'h0) begin errors++; $display("FAIL rst_read_data: got %h/%h want 0/0", data_out1, data_out2); end
    checks++; if (req_ready1 !== 1'b0 || init_done2 !== 1'b0) begin errors++; $display("FAIL rst_read_ctrl: got %b/%b want 0/0", req_ready1, init_done2); end
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stale = stale | rsp_valid1 | rsp_valid2;
    end
    rst_n = 1'b1;
    start = edge_cnt;
    repeat (3) begin
      @(negedge clk);
      stale = stale | rsp_valid1 | rsp_valid2;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rst_stale_rsp: got %b want 0", stale); end
    wait_init(start, n1, n2);
    checks++; if (n1 != DEPTH || n2 != DEPTH) begin errors++; $display("FAIL rst_read_sweep: got %0d/%0d want %0d", n1, n2, DEPTH); end
    clear_model();
    // reset halfway through a clr-started sweep
    write_once(4'd7, 32'h5A5A0001, 4'hF);
    read_once(4'd7, o);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data_out1 !== 32'h0 || data_out2 !== 32'h0) begin errors++; $display("FAIL rst_sweep_data: got %h/%h want 0/0", data_out1, data_out2); end
    checks++; if (init_done1 !== 1'b0 || req_ready2 !== 1'b0) begin errors++; $display("FAIL rst_sweep_ctrl: got %b/%b want 0/0", init_done1, req_ready2); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = edge_cnt;
    wait_init(start, n1, n2);
    checks++; if (n1 != DEPTH || n2 != DEPTH) begin errors++; $display("FAIL rst_sweep_restart: got %0d/%0d want %0d", n1, n2, DEPTH); end
    clear_model();
    read_once(4'd7, o);
    checks++; if (o.v1 !== 1'b1 || o.d1 !== 32'h0 || o.d2 !== 32'h0) begin errors++; $display("FAIL rst_zeroed: got v=%b %h/%h want v=1 0/0", o.v1, o.d1, o.d2); end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_byte_enable();
    test_back_to_back();
    test_parity();
    test_random();
    test_clr_with_read();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
